// File: rtl/l1_mem_arbiter_if.sv
// Bundle between the four L1 cache ext ports, the arbiter and main memory.
// Requests are levels held until the one-cycle response pulse; memory strobes are single-cycle.
interface l1_mem_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_wdata;
  logic [3:0]          req_awvalid;
  logic [3:0]          req_wvalid;
  logic [3:0]          req_arvalid;
  logic [3:0]          req_rvalid;
  logic [3:0]          req_bvalid;
  logic [DATA_W-1:0]   req_rdata;
  logic [1:0]          req_r_resp;
  logic [1:0]          req_w_resp;
  logic [ADDR_W-1:0]   mem_data_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_awvalid;
  logic                mem_wvalid;
  logic                mem_arvalid;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;
  logic [1:0]          mem_r_resp;
  logic                mem_bvalid;
  logic [1:0]          mem_w_resp;

  modport slave (
    input  req_addr, req_wdata, req_awvalid, req_wvalid, req_arvalid,
           mem_rvalid, mem_rdata, mem_r_resp, mem_bvalid, mem_w_resp,
    output req_rvalid, req_bvalid, req_rdata, req_r_resp, req_w_resp,
           mem_data_addr, mem_wdata, mem_awvalid, mem_wvalid, mem_arvalid
  );

  modport master (
    output req_addr, req_wdata, req_awvalid, req_wvalid, req_arvalid,
           mem_rvalid, mem_rdata, mem_r_resp, mem_bvalid, mem_w_resp,
    input  req_rvalid, req_bvalid, req_rdata, req_r_resp, req_w_resp,
           mem_data_addr, mem_wdata, mem_awvalid, mem_wvalid, mem_arvalid
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter serialising four L1 cache miss/writeback ports onto one memory port,
// with a bounded wait so a silent memory returns an error response instead of hanging.
module l1_mem_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  l1_mem_arbiter_if.slave    bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                op_q, op_d;          // 1 = write
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [3:0]          mask_q, mask_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          r_resp_q, r_resp_d;
  logic [1:0]          w_resp_q, w_resp_d;

  logic [3:0]          pending;
  logic                found;
  logic [1:0]          sel;
  logic [1:0]          idx;

  // The served port is masked for one IDLE cycle so its just-dropping valid cannot re-win.
  assign pending = (bus.req_arvalid | (bus.req_awvalid & bus.req_wvalid)) & ~mask_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rr_ptr_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      r_resp_q <= '0;
      w_resp_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rr_ptr_q <= rr_ptr_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      r_resp_q <= r_resp_d;
      w_resp_q <= w_resp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rr_ptr_d = rr_ptr_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    r_resp_d = r_resp_q;
    w_resp_d = w_resp_q;
    found    = 1'b0;
    sel      = rr_ptr_q;
    idx      = rr_ptr_q;

    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end

    case (state_q)
      IDLE: begin
        mask_d = '0;
        if (found) begin
          grant_d  = sel;
          op_d     = bus.req_awvalid[sel] & bus.req_wvalid[sel];
          addr_d   = bus.req_addr[int'(sel)*ADDR_W +: ADDR_W];
          wdata_d  = bus.req_wdata[int'(sel)*DATA_W +: DATA_W];
          rr_ptr_d = sel + 2'd1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!op_q && bus.mem_rvalid) begin
          rdata_d  = bus.mem_rdata;
          r_resp_d = bus.mem_r_resp;
          state_d  = RESP;
        end else if (op_q && bus.mem_bvalid) begin
          w_resp_d = bus.mem_w_resp;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TO_LIMIT) begin
            state_d = RESP;
            if (op_q) begin
              w_resp_d = 2'b10;
            end else begin
              r_resp_d = 2'b10;
              rdata_d  = '0;
            end
          end
        end
      end
      RESP: begin
        mask_d  = 4'b0001 << grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset removes them without waiting for a clock.
  assign bus.mem_arvalid   = (state_q == ISSUE) && !op_q;
  assign bus.mem_awvalid   = (state_q == ISSUE) && op_q;
  assign bus.mem_wvalid    = (state_q == ISSUE) && op_q;
  assign bus.mem_data_addr = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.req_rvalid    = ((state_q == RESP) && !op_q) ? (4'b0001 << grant_q) : 4'b0000;
  assign bus.req_bvalid    = ((state_q == RESP) && op_q)  ? (4'b0001 << grant_q) : 4'b0000;
  assign bus.req_rdata     = rdata_q;
  assign bus.req_r_resp    = r_resp_q;
  assign bus.req_w_resp    = w_resp_q;
  assign dbg_state_o       = state_q;

endmodule
